// File: rtl/seg7_pkg.sv
// Shared symbol codes, segment decode and arbiter state type for the
// seven-segment display arbiter.
package seg7_pkg;

    localparam logic [3:0] SEG_DASH = 4'd10;
    localparam logic [3:0] SEG_A    = 4'd11;
    localparam logic [3:0] SEG_C    = 4'd12;
    localparam logic [3:0] SEG_DARK = 4'd13;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } arb_state_t;

    // Active-low GFEDCBA; codes 13..15 are dark.
    function automatic logic [6:0] seg7_decode(input logic [3:0] sym);
        logic [6:0] seg;
        case (sym)
            4'd0:     seg = 7'b1000000;
            4'd1:     seg = 7'b1111001;
            4'd2:     seg = 7'b0100100;
            4'd3:     seg = 7'b0110000;
            4'd4:     seg = 7'b0011001;
            4'd5:     seg = 7'b0010010;
            4'd6:     seg = 7'b0000010;
            4'd7:     seg = 7'b1111000;
            4'd8:     seg = 7'b0000000;
            4'd9:     seg = 7'b0010000;
            SEG_DASH: seg = 7'b0111111;
            SEG_A:    seg = 7'b0001000;
            SEG_C:    seg = 7'b1000110;
            default:  seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_display_arbiter_scan.sv
// Scan engine: prescaler, scan tick, anode rotation, nibble select and
// registered segment decode for one 16-bit symbol word.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_code,
    input  logic        i_force_dark,
    input  logic        i_blank,
    output logic        o_tick,
    output logic [3:0]  o_digit,
    output logic [6:0]  o_display
);

    logic [SCAN_DIV-1:0] r_presc;
    logic [3:0]          r_digit;
    logic [6:0]          r_seg;
    logic [6:0]          r_display;

    logic                w_tick;
    logic [3:0]          w_digit_nx;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg_nx;

    assign w_tick     = &r_presc;
    assign w_digit_nx = {r_digit[2:0], r_digit[3]};

    always_comb begin
        w_nib = SEG_DARK;
        case (w_digit_nx)
            4'b1110: w_nib = i_code[3:0];
            4'b1101: w_nib = i_code[7:4];
            4'b1011: w_nib = i_code[11:8];
            4'b0111: w_nib = i_code[15:12];
            default: w_nib = SEG_DARK;
        endcase
    end

    // r_seg holds the current digit's pattern between ticks; darkening is
    // applied immediately on the output register so grant and dark edges align.
    assign w_seg_nx = w_tick ? (i_force_dark ? SEG_OFF : seg7_decode(w_nib)) : r_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= '0;
            r_digit   <= 4'b1110;
            r_seg     <= SEG_OFF;
            r_display <= SEG_OFF;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (w_tick) begin
                r_digit <= w_digit_nx;
            end
            r_seg     <= w_seg_nx;
            r_display <= (i_force_dark | i_blank) ? SEG_OFF : w_seg_nx;
        end
    end

    assign o_tick    = w_tick;
    assign o_digit   = r_digit;
    assign o_display = r_display;

endmodule

// File: rtl/seg7_display_arbiter.sv
// Fixed-priority owner arbitration for the shared 4-digit display with
// minimum dwell and a one-frame dark gap; optional blink via DISP_BLINK_EN.
//
// state | meaning
// IDLE  | no owner, display dark
// OWN   | grant one-hot on owner, owner code scanned out
// GAP   | no owner, display dark for exactly four scan ticks
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int SCAN_DIV    = 13,
    parameter int HOLD_CYCLES = 100_000_000
`ifdef DISP_BLINK_EN
    ,
    parameter int BLINK_DIV   = 26
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   code,
    output logic [N_REQ-1:0]      grant,
    output logic [3:0]            DIGIT,
    output logic [6:0]            DISPLAY
`ifdef DISP_BLINK_EN
    ,
    input  logic [N_REQ-1:0]      blink
`endif
);

    localparam int          OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [31:0] HOLD_MAX = 32'(HOLD_CYCLES);

    arb_state_t        r_state;
    arb_state_t        w_state_nx;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     w_owner_nx;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  w_grant_nx;
    logic [31:0]       r_hold;
    logic [1:0]        r_gap_cnt;

    logic [OW-1:0]     w_pick;
    logic              w_any;
    logic              w_own_req;
    logic              w_hi_req;
    logic              w_tick;
    logic [15:0]       w_code;
    logic              w_force_dark;
    logic              w_blank;

    assign w_any = |req;

    always_comb begin
        w_pick    = '0;
        w_own_req = 1'b0;
        w_hi_req  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_pick = OW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (OW'(i) == r_owner && req[i]) begin
                w_own_req = 1'b1;
            end
            if (OW'(i) < r_owner && req[i]) begin
                w_hi_req = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nx = OWN;
                    w_owner_nx = w_pick;
                end
            end
            OWN: begin
                if (!w_own_req || (w_hi_req && r_hold == HOLD_MAX)) begin
                    w_state_nx = GAP;
                end
            end
            GAP: begin
                if (w_tick && r_gap_cnt == 2'd3) begin
                    if (w_any) begin
                        w_state_nx = OWN;
                        w_owner_nx = w_pick;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_grant_nx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_grant_nx[i] = (w_state_nx == OWN) && (OW'(i) == w_owner_nx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_grant   <= '0;
            r_hold    <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_grant <= w_grant_nx;
            if (w_state_nx == OWN && r_state != OWN) begin
                r_hold <= '0;
            end else if (r_state == OWN && r_hold != HOLD_MAX) begin
                r_hold <= r_hold + 32'd1;
            end
            if (r_state != GAP) begin
                r_gap_cnt <= '0;
            end else if (w_tick) begin
                r_gap_cnt <= r_gap_cnt + 2'd1;
            end
        end
    end

    // Select by next owner so the tick that enters OWN already shows its code.
    always_comb begin
        w_code = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (OW'(i) == w_owner_nx) begin
                w_code = code[16*i +: 16];
            end
        end
    end

    assign w_force_dark = (w_state_nx != OWN);

`ifdef DISP_BLINK_EN
    logic [BLINK_DIV-1:0] r_blink_cnt;
    logic                 w_blink_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_comb begin
        w_blink_sel = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (OW'(i) == w_owner_nx && blink[i]) begin
                w_blink_sel = 1'b1;
            end
        end
    end

    assign w_blank = w_blink_sel && r_blink_cnt[BLINK_DIV-1];
`else
    assign w_blank = 1'b0;
`endif

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk          (clk),
        .rst          (rst),
        .i_code       (w_code),
        .i_force_dark (w_force_dark),
        .i_blank      (w_blank),
        .o_tick       (w_tick),
        .o_digit      (DIGIT),
        .o_display    (DISPLAY)
    );

    assign grant = r_grant;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter (SCAN_DIV=2, HOLD_CYCLES=20);
// blink duty is checked when DISP_BLINK_EN is defined.
module tb_seg7_display_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [47:0] code;
    logic [2:0]  grant;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;
`ifdef DISP_BLINK_EN
    logic [2:0]  blink;
`endif

    int n_checks = 0;
    int n_errors = 0;

    seg7_display_arbiter #(
        .N_REQ       (3),
        .SCAN_DIV    (2),
        .HOLD_CYCLES (20)
`ifdef DISP_BLINK_EN
        ,
        .BLINK_DIV   (4)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .code    (code),
        .grant   (grant),
        .DIGIT   (DIGIT),
        .DISPLAY (DISPLAY)
`ifdef DISP_BLINK_EN
        ,
        .blink   (blink)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the sample where grant has just dropped; follows the gap to its end.
    task automatic watch_gap(input string tag, input logic [2:0] exp_grant);
        int         changes = 0;
        int         cyc = 0;
        logic       dark_ok = 1'b1;
        logic [3:0] prev;
        prev = DIGIT;
        while (grant == 3'b000 && cyc < 40) begin
            if (DISPLAY != 7'b1111111) dark_ok = 1'b0;
            @(negedge clk);
            cyc++;
            if (DIGIT != prev) changes++;
            prev = DIGIT;
        end
        check({tag, "_ticks"}, changes, 4);
        check({tag, "_dark"}, dark_ok, 1);
        check({tag, "_grant"}, grant, exp_grant);
    endtask

    function automatic logic [6:0] exp_bd15(input logic [3:0] dig);
        case (dig)
            4'b1110: return 7'b0010010;
            4'b1101: return 7'b1111001;
            4'b1011: return 7'b1111111;
            4'b0111: return 7'b0001000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    initial begin
        int         k;
        int         cnt;
        int         cyc;
        int         dark_n;
        logic       ok;
        logic [3:0] prev;

        rst  = 1'b1;
        req  = 3'b000;
        code = {16'h0000, 16'hBD15, 16'h0000};
`ifdef DISP_BLINK_EN
        blink = 3'b001;
`endif
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 3'b000);
        check("rst_digit", DIGIT, 4'b1110);
        check("rst_display", DISPLAY, 7'b1111111);
        rst = 1'b0;

        // Single owner, decode of BD15 over four ticks
        repeat (3) @(negedge clk);
        req = 3'b010;
        @(negedge clk);
        check("own1_grant", grant, 3'b010);
        prev = DIGIT;
        cnt  = 0;
        cyc  = 0;
        while (cnt < 4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (DIGIT != prev) begin
                check("scan_rotate", DIGIT, {prev[2:0], prev[3]});
                check("scan_seg", DISPLAY, exp_bd15(DIGIT));
                cnt++;
                prev = DIGIT;
            end
        end
        check("scan_ticks", cnt, 4);

        // Release to idle, then no-gap grant from IDLE
        req = 3'b000;
        @(negedge clk);
        check("rel_grant", grant, 3'b000);
        check("rel_dark", DISPLAY, 7'b1111111);
        ok = 1'b1;
        repeat (24) begin
            @(negedge clk);
            if (grant != 3'b000 || DISPLAY != 7'b1111111) ok = 1'b0;
        end
        check("idle_dark", ok, 1);
        req = 3'b100;
        @(negedge clk);
        check("idle_nogap", grant, 3'b100);

        // Dwell guard: req[0] at +5, preemption only once hold reaches 20
        for (k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 5) req = 3'b101;
        end
        check("dwell_hold19", grant, 3'b100);
        k = 19;
        while (grant != 3'b000 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("dwell_drop_cycle", k, 21);
        watch_gap("dwell_gap", 3'b001);

        // Lower priority never preempts
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (grant == 3'b001) cnt++;
        end
        check("nolow_preempt", cnt, 100);

        // Owner 0 releases, client 1 takes over after a gap
        req = 3'b010;
        @(negedge clk);
        check("hand1_drop", grant, 3'b000);
        watch_gap("hand1_gap", 3'b010);

        // Release and higher-priority request in the same cycle: one gap
        req = 3'b001;
        @(negedge clk);
        check("simul_drop", grant, 3'b000);
        watch_gap("simul_gap", 3'b001);

        // Back to idle, then simultaneous 101 from IDLE
        req = 3'b000;
        repeat (25) @(negedge clk);
        check("idle2_grant", grant, 3'b000);
        req = 3'b101;
        @(negedge clk);
        check("prio_idle", grant, 3'b001);

        repeat (8) @(negedge clk);
        dark_n = 0;
        repeat (32) begin
            @(negedge clk);
            if (DISPLAY == 7'b1111111) dark_n++;
        end
`ifdef DISP_BLINK_EN
        check("blink_dark", dark_n, 16);
`else
        check("noblink_dark", dark_n, 0);
`endif

        // Asynchronous reset mid-frame while owning
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_grant", grant, 3'b000);
        check("arst_digit", DIGIT, 4'b1110);
        check("arst_display", DISPLAY, 7'b1111111);
        req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_grant", grant, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
